// File: rtl/mem_writeback_pkg.sv
// Shared opcode/funct3 constants, instruction class and FSM state types for mem_writeback.
package mem_writeback_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [2:0] F3_W       = 3'b010;

  typedef enum logic [1:0] {CLS_NOP, CLS_ALU, CLS_LOAD, CLS_STORE} instr_class_e;
  typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_WB} state_e;

  // Only word loads/stores touch memory; a 32-bit opcode we do not know is a no-op.
  function automatic instr_class_e classify(input logic [31:0] ir);
    logic [6:0] opc;
    logic [2:0] f3;
    opc = ir[6:0];
    f3  = ir[14:12];
    if (ir == 32'h0)
      classify = CLS_NOP;
    else if (opc == OPC_LOAD && f3 == F3_W)
      classify = CLS_LOAD;
    else if (opc == OPC_STORE && f3 == F3_W)
      classify = CLS_STORE;
    else if (opc[1:0] == 2'b11 &&
             opc != OPC_LOAD && opc != OPC_STORE && opc != OPC_OP &&
             opc != OPC_OP_IMM && opc != OPC_LUI && opc != OPC_JAL)
      classify = CLS_NOP;
    else
      classify = CLS_ALU;
  endfunction

endpackage

// File: rtl/mem_writeback_reg_file.sv
// Register file: two combinational read ports, one write port, x0 reads as zero.
module reg_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  output logic [XLEN-1:0]          rdata1,
  output logic [XLEN-1:0]          rdata2
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/mem_writeback.sv
// Memory/writeback stage: word load/store handshake, then one-cycle register writeback (MEMWB_BYPASS_EN forwards wb_data to reads).
// Latency: ALU result writes back the cycle after acceptance; loads the cycle after dmem_ack.
// Backpressure: in_ready only in IDLE; MEM waits indefinitely for dmem_ack.
module mem_writeback
  import mem_writeback_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     ir,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] store_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  state_e          state, next_state;
  instr_class_e    cls_in, cls_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] addr_q, wdata_q, res_q;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;
  logic            accept;

  assign cls_in = classify(ir);
  assign accept = (state == ST_IDLE) && in_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cls_q   <= CLS_NOP;
      rd_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        cls_q   <= cls_in;
        rd_q    <= ir[11:7];
        addr_q  <= alu_out;
        wdata_q <= store_data;
        res_q   <= alu_out;
      end else if (state == ST_MEM && dmem_ack && cls_q == CLS_LOAD) begin
        res_q <= dmem_rdata;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          case (cls_in)
            CLS_LOAD, CLS_STORE: next_state = ST_MEM;
            CLS_ALU:             next_state = ST_WB;
            default:             next_state = ST_IDLE;
          endcase
        end
      end
      ST_MEM: begin
        if (dmem_ack) next_state = (cls_q == CLS_LOAD) ? ST_WB : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Address/data come straight from the latched registers so they stay stable for the whole request.
  assign in_ready   = (state == ST_IDLE);
  assign dmem_req   = (state == ST_MEM);
  assign dmem_we    = (state == ST_MEM) && (cls_q == CLS_STORE);
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid   = (state == ST_WB);
  assign wb_rd      = rd_q;
  assign wb_data    = res_q;

  reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_reg_file (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_valid),
    .waddr  (rd_q),
    .wdata  (res_q),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

`ifdef MEMWB_BYPASS_EN
  assign rs1_data = (wb_valid && rd_q != '0 && rs1_addr == rd_q) ? res_q : rf_rdata1;
  assign rs2_data = (wb_valid && rd_q != '0 && rs2_addr == rd_q) ? res_q : rf_rdata2;
`else
  assign rs1_data = rf_rdata1;
  assign rs2_data = rf_rdata2;
`endif

endmodule
